// File: rtl/gb_cpu_common_pkg.sv
// Shared CPU-side types: IDU opcodes and instruction, bus T-state and bus request.
// Ports: none (package).
package gb_cpu_common_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDU_NOP = 2'd0,
    IDU_INC = 2'd1,
    IDU_DEC = 2'd2
  } idu_op_t;

  typedef struct packed {
    idu_op_t           op;
    logic [ADDR_W-1:0] operand;
  } idu_instruction_t;

  typedef enum logic [2:0] {
    TS_IDLE = 3'd0,
    TS_T1   = 3'd1,
    TS_T2   = 3'd2,
    TS_T3   = 3'd3,
    TS_T4   = 3'd4
  } bus_tstate_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    idu_op_t           idu_op;
  } bus_req_t;

  // Any encoding outside NOP/INC/DEC collapses to NOP.
  function automatic idu_op_t idu_op_sanitize(input idu_op_t op);
    case (op)
      IDU_INC: return IDU_INC;
      IDU_DEC: return IDU_DEC;
      default: return IDU_NOP;
    endcase
  endfunction

endpackage

// File: rtl/gb_cpu_idu.sv
// Increment/decrement unit: 16-bit modulo add/sub of one on the operand.
// Ports: instr (opcode + operand) in, result_c (combinational result) out.
module gb_cpu_idu
  import gb_cpu_common_pkg::*;
(
  input  idu_instruction_t  instr,
  output logic [ADDR_W-1:0] result_c
);

  always_comb begin
    result_c = instr.operand;
    case (instr.op)
      IDU_INC: result_c = instr.operand + ADDR_W'(1);
      IDU_DEC: result_c = instr.operand - ADDR_W'(1);
      default: result_c = instr.operand;
    endcase
  end

endmodule

// File: rtl/gb_cpu_bus_ctrl.sv
// CPU bus controller: runs one 4 T-cycle M-cycle per accepted request,
// drives read/write strobes, captures read data and the IDU-adjusted address.
// Ports: clk/reset (sync, active-high); req_* request handshake and payload;
// bus_* external bus; rsp_* completion pulse, read data and next address.
module gb_cpu_bus_ctrl
  import gb_cpu_common_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  input  logic [1:0]  req_idu_op,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  input  logic [7:0]  bus_rdata,
  output logic        bus_rd,
  output logic        bus_wr,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic [15:0] rsp_addr_next
);

  bus_tstate_t       state_q, state_d;
  bus_req_t          req_q, req_d;
  logic              ready_q, ready_d;
  logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
  logic              bus_rd_q, bus_rd_d;
  logic              bus_wr_q, bus_wr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [ADDR_W-1:0] rsp_addr_next_q, rsp_addr_next_d;
  logic              accept_c;
  idu_instruction_t  idu_instr_c;
  logic [ADDR_W-1:0] idu_result_c;

  assign idu_instr_c = '{op: idu_op_sanitize(req_q.idu_op), operand: req_q.addr};

  gb_cpu_idu u_idu (
    .instr    (idu_instr_c),
    .result_c (idu_result_c)
  );

  // Next state plus next registered outputs; outputs are derived from the
  // upcoming state so they line up with the T-state they belong to.
  always_comb begin
    state_d         = state_q;
    req_d           = req_q;
    rsp_rdata_d     = rsp_rdata_q;
    rsp_addr_next_d = rsp_addr_next_q;
    accept_c        = req_valid && ready_q;

    case (state_q)
      TS_IDLE: if (accept_c) state_d = TS_T1;
      TS_T1:   state_d = TS_T2;
      TS_T2:   state_d = TS_T3;
      TS_T3:   state_d = TS_T4;
      TS_T4:   state_d = accept_c ? TS_T1 : TS_IDLE;
      default: state_d = TS_IDLE;
    endcase

    if (accept_c) begin
      req_d = '{write:  req_write,
                addr:   req_addr,
                wdata:  req_wdata,
                idu_op: idu_op_t'(req_idu_op)};
    end

    // End of T3: capture read data and the IDU result for the response.
    if (state_q == TS_T3) begin
      rsp_rdata_d     = req_q.write ? DATA_W'(0) : bus_rdata;
      rsp_addr_next_d = idu_result_c;
    end

    ready_d     = (state_d == TS_IDLE) || (state_d == TS_T4);
    bus_addr_d  = (state_d != TS_IDLE) ? req_d.addr : bus_addr_q;
    bus_rd_d    = !req_d.write && (state_d inside {TS_T1, TS_T2, TS_T3});
    bus_wr_d    = req_d.write && (state_d inside {TS_T2, TS_T3});
    bus_wdata_d = (req_d.write && (state_d inside {TS_T2, TS_T3, TS_T4}))
                  ? req_d.wdata : bus_wdata_q;
    rsp_valid_d = (state_d == TS_T4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= TS_IDLE;
      req_q           <= '0;
      ready_q         <= 1'b1;
      bus_addr_q      <= '0;
      bus_wdata_q     <= '0;
      bus_rd_q        <= 1'b0;
      bus_wr_q        <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_rdata_q     <= '0;
      rsp_addr_next_q <= '0;
    end else begin
      state_q         <= state_d;
      req_q           <= req_d;
      ready_q         <= ready_d;
      bus_addr_q      <= bus_addr_d;
      bus_wdata_q     <= bus_wdata_d;
      bus_rd_q        <= bus_rd_d;
      bus_wr_q        <= bus_wr_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_rdata_q     <= rsp_rdata_d;
      rsp_addr_next_q <= rsp_addr_next_d;
    end
  end

  assign req_ready     = ready_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign bus_rd        = bus_rd_q;
  assign bus_wr        = bus_wr_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_addr_next = rsp_addr_next_q;

endmodule

// File: tb/tb_gb_cpu_bus_ctrl.sv
// Bench for gb_cpu_bus_ctrl: directed scenarios followed by random traffic,
// every cycle compared against a transaction-level reference model.
module tb_gb_cpu_bus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic [1:0]  req_idu_op;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wdata;
  logic [7:0]  bus_rdata;
  logic        bus_rd;
  logic        bus_wr;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic [15:0] rsp_addr_next;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: k = cycle index inside the M-cycle (0 = idle, 1..4 = T1..T4).
  int          k;
  logic        m_w;
  logic [15:0] m_addr;
  logic [7:0]  m_wd;
  logic [1:0]  m_op;
  logic [15:0] e_baddr;
  logic [7:0]  e_bwd;
  logic [7:0]  e_rdata;
  logic [15:0] e_next;
  int          rsp_cnt;

  gb_cpu_bus_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_idu_op    (req_idu_op),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_rdata     (bus_rdata),
    .bus_rd        (bus_rd),
    .bus_wr        (bus_wr),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_addr_next (rsp_addr_next)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] ref_idu(input logic [15:0] a, input logic [1:0] op);
    if (op == 2'd1) return a + 16'd1;
    if (op == 2'd2) return a - 16'd1;
    return a;
  endfunction

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_next();
    logic acc;
    if (reset) begin
      k = 0; m_w = 0; m_addr = 0; m_wd = 0; m_op = 0;
      e_baddr = 0; e_bwd = 0; e_rdata = 0; e_next = 0;
      return;
    end
    acc = req_valid && (k == 0 || k == 4);
    if (k == 3) begin
      e_rdata = m_w ? 8'h00 : bus_rdata;
      e_next  = ref_idu(m_addr, m_op);
    end
    if (acc) begin
      m_w = req_write; m_addr = req_addr; m_wd = req_wdata; m_op = req_idu_op;
      k = 1;
    end else if (k >= 1 && k <= 3) begin
      k = k + 1;
    end else begin
      k = 0;
    end
    if (k != 0) e_baddr = m_addr;
    if (m_w && k >= 2) e_bwd = m_wd;
  endtask

  task automatic check_all();
    check_eq("req_ready", req_ready, (k == 0 || k == 4));
    check_eq("bus_rd", bus_rd, (!m_w && k >= 1 && k <= 3));
    check_eq("bus_wr", bus_wr, (m_w && (k == 2 || k == 3)));
    check_eq("strobe_excl", bus_rd & bus_wr, 1'b0);
    check_eq("rsp_valid", rsp_valid, (k == 4));
    check_eq("bus_addr", bus_addr, e_baddr);
    check_eq("bus_wdata", bus_wdata, e_bwd);
    check_eq("rsp_rdata", rsp_rdata, e_rdata);
    check_eq("rsp_addr_next", rsp_addr_next, e_next);
    if (rsp_valid) rsp_cnt++;
  endtask

  // Inputs are driven at the falling edge; DUT samples at the rising edge.
  task automatic step();
    model_next();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic set_req(input logic v, input logic w, input logic [15:0] a,
                         input logic [7:0] d, input logic [1:0] op);
    req_valid = v; req_write = w; req_addr = a; req_wdata = d; req_idu_op = op;
  endtask

  // One request, then scrambled inputs while it is in flight; ends in T4.
  task automatic one_txn(input logic w, input logic [15:0] a, input logic [7:0] d,
                         input logic [1:0] op, input logic [7:0] rdata);
    set_req(1'b1, w, a, d, op);
    bus_rdata = rdata;
    step();
    set_req(1'b0, ~w, 16'($urandom), 8'($urandom), 2'($urandom));
    for (int i = 0; i < 3; i++) step();
  endtask

  logic [15:0] b2b_addr [3] = '{16'h1234, 16'h8000, 16'hFFFF};
  logic        b2b_w    [3] = '{1'b0, 1'b1, 1'b0};
  logic [1:0]  b2b_op   [3] = '{2'd1, 2'd2, 2'd1};

  initial begin
    int idx;
    int cnt0;
    k = 0; m_w = 0; m_addr = 0; m_wd = 0; m_op = 0;
    e_baddr = 0; e_bwd = 0; e_rdata = 0; e_next = 0; rsp_cnt = 0;
    reset = 1'b1;
    bus_rdata = 8'h00;
    set_req(1'b0, 1'b0, 16'h0, 8'h0, 2'd0);
    @(negedge clk);
    step();
    step();
    check_eq("reset_ready", req_ready, 1'b1);
    reset = 1'b0;
    step();
    check_eq("post_reset_ready", req_ready, 1'b1);

    // Read with INC.
    one_txn(1'b0, 16'hC000, 8'h00, 2'd1, 8'h5A);
    check_eq("rd_valid", rsp_valid, 1'b1);
    check_eq("rd_rdata", rsp_rdata, 8'h5A);
    check_eq("rd_next", rsp_addr_next, 16'hC001);
    step();

    // Write with DEC.
    one_txn(1'b1, 16'hFF80, 8'h3C, 2'd2, 8'hEE);
    check_eq("wr_rdata", rsp_rdata, 8'h00);
    check_eq("wr_next", rsp_addr_next, 16'hFF7F);
    check_eq("wr_wdata", bus_wdata, 8'h3C);
    step();

    // Wrap-around in both directions, plus out-of-range opcode acting as NOP.
    one_txn(1'b0, 16'hFFFF, 8'h00, 2'd1, 8'h11);
    check_eq("wrap_inc", rsp_addr_next, 16'h0000);
    step();
    one_txn(1'b0, 16'h0000, 8'h00, 2'd2, 8'h22);
    check_eq("wrap_dec", rsp_addr_next, 16'hFFFF);
    step();
    one_txn(1'b1, 16'h4321, 8'h77, 2'd3, 8'h33);
    check_eq("bad_op_nop", rsp_addr_next, 16'h4321);
    step();

    // Back-to-back: valid held high, new payload presented whenever acceptable.
    cnt0 = rsp_cnt;
    idx = 0;
    for (int i = 0; i < 12; i++) begin
      if ((k == 0 || k == 4) && idx < 3) begin
        set_req(1'b1, b2b_w[idx], b2b_addr[idx], 8'(8'hA0 + idx), b2b_op[idx]);
        bus_rdata = 8'(8'h40 + idx);
        idx++;
      end
      step();
      if (i >= 1 && i <= 10) check_eq("b2b_busy", req_ready, (k == 4));
    end
    req_valid = 1'b0;
    check_eq("b2b_rsp_count", rsp_cnt - cnt0, 3);
    check_eq("b2b_last_next", rsp_addr_next, 16'h0000);
    step();

    // Reset during T2 of a write.
    set_req(1'b1, 1'b1, 16'hA5A5, 8'h99, 2'd1);
    step();
    req_valid = 1'b0;
    step();
    check_eq("abort_wr_t2", bus_wr, 1'b1);
    reset = 1'b1;
    step();
    check_eq("abort_wr", bus_wr, 1'b0);
    check_eq("abort_valid", rsp_valid, 1'b0);
    check_eq("abort_addr", bus_addr, 16'h0000);
    reset = 1'b0;
    step();
    check_eq("abort_ready", req_ready, 1'b1);
    check_eq("abort_no_rsp", rsp_valid, 1'b0);

    // req_valid pulsed in T2 of a read is ignored.
    set_req(1'b1, 1'b0, 16'h0100, 8'h00, 2'd0);
    bus_rdata = 8'h6B;
    step();
    req_valid = 1'b0;
    step();
    set_req(1'b1, 1'b1, 16'hBEEF, 8'h12, 2'd2);
    step();
    req_valid = 1'b0;
    step();
    step();
    check_eq("pulse_ignored_idle", req_ready, 1'b1);
    check_eq("pulse_ignored_next", rsp_addr_next, 16'h0100);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      set_req(1'($urandom_range(0, 1)), 1'($urandom), 16'($urandom), 8'($urandom),
              2'($urandom));
      bus_rdata = 8'($urandom);
      reset = ($urandom_range(0, 63) == 0);
      step();
    end
    reset = 1'b0;
    req_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
